// File: rtl/latch_serial_tx_if.sv
// Handshake and serial-output bundle for latch_serial_tx.
// The producer side uses the master modport; the transmitter uses the slave modport.
interface latch_serial_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             out_d;
  logic             out_d_bar;
  logic             out_bit_valid;
  logic             out_busy;
  logic             out_done;

  modport master (
    output in_data, in_valid,
    input  in_ready, out_d, out_d_bar, out_bit_valid, out_busy, out_done
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out_d, out_d_bar, out_bit_valid, out_busy, out_done
  );
endinterface

// File: rtl/latch_serial_tx.sv
// MSB-first parallel-to-serial driver with complementary data outputs for latch/FF capture chains.
// Optional even-parity trailer bit is enabled by defining LATCH_SERIAL_TX_PARITY_EN.
module latch_serial_tx #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              reset,
  latch_serial_tx_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
`ifdef LATCH_SERIAL_TX_PARITY_EN
    PARITY = 2'd2,
`endif
    DONE   = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_d;
  logic             r_d_bar;
  logic             r_bit_valid;
  logic             r_busy;
  logic             r_done;
`ifdef LATCH_SERIAL_TX_PARITY_EN
  logic             r_par;
`endif

  // r_shift holds the bits still to be sent, left-aligned; the MSB goes out directly on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_d         <= 1'b0;
      r_d_bar     <= 1'b1;
      r_bit_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef LATCH_SERIAL_TX_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_state     <= SHIFT;
            r_shift     <= {bus.in_data[WIDTH-2:0], 1'b0};
            r_cnt       <= CW'(WIDTH - 1);
            r_d         <= bus.in_data[WIDTH-1];
            r_d_bar     <= ~bus.in_data[WIDTH-1];
            r_bit_valid <= 1'b1;
            r_busy      <= 1'b1;
`ifdef LATCH_SERIAL_TX_PARITY_EN
            r_par       <= ^bus.in_data;
`endif
          end
        end
        SHIFT: begin
          if (r_cnt == '0) begin
`ifdef LATCH_SERIAL_TX_PARITY_EN
            r_state     <= PARITY;
            r_d         <= r_par;
            r_d_bar     <= ~r_par;
`else
            r_state     <= DONE;
            r_bit_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
`endif
          end else begin
            r_d     <= r_shift[WIDTH-1];
            r_d_bar <= ~r_shift[WIDTH-1];
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt - CW'(1);
          end
        end
`ifdef LATCH_SERIAL_TX_PARITY_EN
        PARITY: begin
          r_state     <= DONE;
          r_bit_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
        end
`endif
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready      = (r_state == IDLE);
  assign bus.out_d         = r_d;
  assign bus.out_d_bar     = r_d_bar;
  assign bus.out_bit_valid = r_bit_valid;
  assign bus.out_busy      = r_busy;
  assign bus.out_done      = r_done;
endmodule

// File: tb/tb_latch_serial_tx.sv
// Self-checking bench for latch_serial_tx: expected serial bits are queued at accept and popped on out_bit_valid.
module tb_latch_serial_tx;
  localparam int unsigned WIDTH = 8;
`ifdef LATCH_SERIAL_TX_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int P = NB + 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic exp_q[$];

  latch_serial_tx_if #(.WIDTH(WIDTH)) bus ();
  latch_serial_tx #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic push_word(input logic [WIDTH-1:0] w);
    for (int i = int'(WIDTH) - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef LATCH_SERIAL_TX_PARITY_EN
    exp_q.push_back(^w);
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.out_d !== 1'b0) begin failures++; $display("FAIL reset out_d got=%b want=0", bus.out_d); end
    checks++; if (bus.out_d_bar !== 1'b1) begin failures++; $display("FAIL reset out_d_bar got=%b want=1", bus.out_d_bar); end
    checks++; if (bus.out_bit_valid !== 1'b0) begin failures++; $display("FAIL reset bit_valid got=%b want=0", bus.out_bit_valid); end
    checks++; if (bus.out_busy !== 1'b0) begin failures++; $display("FAIL reset busy got=%b want=0", bus.out_busy); end
    checks++; if (bus.out_done !== 1'b0) begin failures++; $display("FAIL reset done got=%b want=0", bus.out_done); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset in_ready_after_release got=%b want=1", bus.in_ready); end
    checks++; if (bus.out_d_bar !== ~bus.out_d) begin failures++; $display("FAIL reset d_bar got=%b want=%b", bus.out_d_bar, ~bus.out_d); end
  endtask

  task automatic test_single();
    logic e;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL single ready_pre got=%b want=1", bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_data = 8'hA5; push_word(8'hA5);
    for (int cyc = 1; cyc <= P; cyc++) begin
      @(negedge clk);
      bus.in_valid = 1'b0; bus.in_data = 8'h5A;
      checks++; if (bus.out_d_bar !== ~bus.out_d) begin failures++; $display("FAIL single d_bar cyc=%0d got=%b want=%b", cyc, bus.out_d_bar, ~bus.out_d); end
      checks++; if (bus.out_bit_valid !== (cyc <= NB)) begin failures++; $display("FAIL single bit_valid cyc=%0d got=%b want=%b", cyc, bus.out_bit_valid, (cyc <= NB)); end
      checks++; if (bus.out_busy !== (cyc <= NB)) begin failures++; $display("FAIL single busy cyc=%0d got=%b want=%b", cyc, bus.out_busy, (cyc <= NB)); end
      checks++; if (bus.out_done !== (cyc == NB + 1)) begin failures++; $display("FAIL single done cyc=%0d got=%b want=%b", cyc, bus.out_done, (cyc == NB + 1)); end
      checks++; if (bus.in_ready !== (cyc == P)) begin failures++; $display("FAIL single in_ready cyc=%0d got=%b want=%b", cyc, bus.in_ready, (cyc == P)); end
      if (bus.out_bit_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL single extra_bit cyc=%0d got=%b want=none", cyc, bus.out_d); end
        else begin
          e = exp_q.pop_front();
          if (bus.out_d !== e) begin failures++; $display("FAIL single out_d cyc=%0d got=%b want=%b", cyc, bus.out_d, e); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single missing_bits got=%0d want=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    logic e;
    int   gap = 0;
    int   dones = 0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b ready_pre got=%b want=1", bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_data = 8'h3C; push_word(8'h3C);
    for (int cyc = 1; cyc <= 2 * P; cyc++) begin
      int loc;
      @(negedge clk);
      loc = (cyc - 1) % P + 1;
      if (cyc == 1) bus.in_data = 8'hC3;
      if (cyc == P) push_word(8'hC3);
      if (cyc == P + 1) bus.in_valid = 1'b0;
      checks++; if (bus.out_d_bar !== ~bus.out_d) begin failures++; $display("FAIL b2b d_bar cyc=%0d got=%b want=%b", cyc, bus.out_d_bar, ~bus.out_d); end
      checks++; if (bus.out_bit_valid !== (loc <= NB)) begin failures++; $display("FAIL b2b bit_valid cyc=%0d got=%b want=%b", cyc, bus.out_bit_valid, (loc <= NB)); end
      checks++; if (bus.out_done !== (loc == NB + 1)) begin failures++; $display("FAIL b2b done cyc=%0d got=%b want=%b", cyc, bus.out_done, (loc == NB + 1)); end
      checks++; if (bus.in_ready !== (loc == P)) begin failures++; $display("FAIL b2b in_ready cyc=%0d got=%b want=%b", cyc, bus.in_ready, (loc == P)); end
      if (bus.out_bit_valid !== 1'b1 && cyc > NB && cyc <= P + 1) gap++;
      if (bus.out_done === 1'b1) dones++;
      if (bus.out_bit_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL b2b extra_bit cyc=%0d got=%b want=none", cyc, bus.out_d); end
        else begin
          e = exp_q.pop_front();
          if (bus.out_d !== e) begin failures++; $display("FAIL b2b out_d cyc=%0d got=%b want=%b", cyc, bus.out_d, e); end
        end
      end
    end
    checks++; if (gap != 2) begin failures++; $display("FAIL b2b idle_gap got=%0d want=2", gap); end
    checks++; if (dones != 2) begin failures++; $display("FAIL b2b done_pulses got=%0d want=2", dones); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b missing_bits got=%0d want=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_ignore_busy();
    logic e;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 8'hFF; push_word(8'hFF);
    for (int cyc = 1; cyc <= P; cyc++) begin
      @(negedge clk);
      checks++; if (bus.out_d_bar !== ~bus.out_d) begin failures++; $display("FAIL ignore d_bar cyc=%0d got=%b want=%b", cyc, bus.out_d_bar, ~bus.out_d); end
      checks++; if (bus.in_ready !== (cyc == P)) begin failures++; $display("FAIL ignore in_ready cyc=%0d got=%b want=%b", cyc, bus.in_ready, (cyc == P)); end
      checks++; if (bus.out_done !== (cyc == NB + 1)) begin failures++; $display("FAIL ignore done cyc=%0d got=%b want=%b", cyc, bus.out_done, (cyc == NB + 1)); end
      if (bus.out_bit_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL ignore extra_bit cyc=%0d got=%b want=none", cyc, bus.out_d); end
        else begin
          e = exp_q.pop_front();
          if (bus.out_d !== e) begin failures++; $display("FAIL ignore out_d cyc=%0d got=%b want=%b", cyc, bus.out_d, e); end
        end
      end
      bus.in_valid = (cyc == 3 || cyc == 6);
      bus.in_data  = 8'h00;
    end
    @(negedge clk);
    checks++; if (bus.out_bit_valid !== 1'b0) begin failures++; $display("FAIL ignore spurious_accept got=%b want=0", bus.out_bit_valid); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ignore missing_bits got=%0d want=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_abort();
    logic e;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 8'hF0; push_word(8'hF0);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++; if (bus.out_bit_valid !== 1'b1) begin failures++; $display("FAIL abort bit_valid cyc=%0d got=%b want=1", cyc, bus.out_bit_valid); end
      e = exp_q.pop_front();
      checks++; if (bus.out_d !== e) begin failures++; $display("FAIL abort out_d cyc=%0d got=%b want=%b", cyc, bus.out_d, e); end
    end
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.out_d !== 1'b0) begin failures++; $display("FAIL abort out_d_rst got=%b want=0", bus.out_d); end
    checks++; if (bus.out_d_bar !== 1'b1) begin failures++; $display("FAIL abort d_bar_rst got=%b want=1", bus.out_d_bar); end
    checks++; if (bus.out_bit_valid !== 1'b0) begin failures++; $display("FAIL abort bit_valid_rst got=%b want=0", bus.out_bit_valid); end
    checks++; if (bus.out_busy !== 1'b0) begin failures++; $display("FAIL abort busy_rst got=%b want=0", bus.out_busy); end
    checks++; if (bus.out_done !== 1'b0) begin failures++; $display("FAIL abort done_rst got=%b want=0", bus.out_done); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL abort ready_rst got=%b want=1", bus.in_ready); end
    @(negedge clk);
    checks++; if (bus.out_done !== 1'b0) begin failures++; $display("FAIL abort late_done got=%b want=0", bus.out_done); end
    bus.in_valid = 1'b1; bus.in_data = 8'h81; push_word(8'h81);
    for (int cyc = 1; cyc <= P; cyc++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++; if (bus.out_d_bar !== ~bus.out_d) begin failures++; $display("FAIL abort d_bar cyc=%0d got=%b want=%b", cyc, bus.out_d_bar, ~bus.out_d); end
      checks++; if (bus.out_bit_valid !== (cyc <= NB)) begin failures++; $display("FAIL abort bit_valid2 cyc=%0d got=%b want=%b", cyc, bus.out_bit_valid, (cyc <= NB)); end
      checks++; if (bus.out_done !== (cyc == NB + 1)) begin failures++; $display("FAIL abort done2 cyc=%0d got=%b want=%b", cyc, bus.out_done, (cyc == NB + 1)); end
      if (bus.out_bit_valid === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++; if (bus.out_d !== e) begin failures++; $display("FAIL abort out_d2 cyc=%0d got=%b want=%b", cyc, bus.out_d, e); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL abort missing_bits got=%0d want=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_parity();
    logic [WIDTH-1:0] words [2];
    logic             pexp  [2];
    logic             e;
    words[0] = 8'hA5; pexp[0] = 1'b0;
    words[1] = 8'h07; pexp[1] = 1'b1;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = words[w]; push_word(words[w]);
      for (int cyc = 1; cyc <= P; cyc++) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_d_bar !== ~bus.out_d) begin failures++; $display("FAIL parity d_bar w=%0d cyc=%0d got=%b want=%b", w, cyc, bus.out_d_bar, ~bus.out_d); end
        checks++; if (bus.out_bit_valid !== (cyc <= NB)) begin failures++; $display("FAIL parity bit_valid w=%0d cyc=%0d got=%b want=%b", w, cyc, bus.out_bit_valid, (cyc <= NB)); end
        checks++; if (bus.out_done !== (cyc == NB + 1)) begin failures++; $display("FAIL parity done w=%0d cyc=%0d got=%b want=%b", w, cyc, bus.out_done, (cyc == NB + 1)); end
        if (bus.out_bit_valid === 1'b1 && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++; if (bus.out_d !== e) begin failures++; $display("FAIL parity out_d w=%0d cyc=%0d got=%b want=%b", w, cyc, bus.out_d, e); end
        end
        // Trailer bit against hand-computed even parity; without the feature this is the LSB
        if (cyc == NB) begin
          e = (NB == int'(WIDTH)) ? words[w][0] : pexp[w];
          checks++; if (bus.out_d !== e) begin failures++; $display("FAIL parity last_bit w=%0d got=%b want=%b", w, bus.out_d, e); end
        end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL parity missing_bits w=%0d got=%0d want=0", w, exp_q.size()); exp_q.delete(); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
